// File: rtl/ram_2port_pipe.sv
// Purpose: simple dual-port RAM (1 write, 1 read) with byte enables and a self-initialising sweep.
// Latency: read_valid/read_data follow an accepted read by READ_LATENCY (1 or 2) cycles, fully pipelined.
// Backpressure: none; requests are dropped while init_busy is high or rst is asserted.
// Ports: clk, rst (sync, active high); init_busy (sweep running);
//        write_en/write_addr/write_be/write_data (byte-masked write);
//        read_en/read_addr (read request); read_valid/read_data (result, data held between pulses).
// Option: define RAM_2PORT_PIPE_BYPASS_EN to forward same-cycle same-address write bytes into the read;
//         otherwise such a read returns the old word (read-before-write).
module ram_2port_pipe #(
    parameter int                    ADDR_WIDTH   = 6,
    parameter int                    DATA_WIDTH   = 64,
    parameter int                    READ_LATENCY = 1,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE   = '0
) (
    input  logic                      clk,
    input  logic                      rst,
    output logic                      init_busy,
    input  logic                      write_en,
    input  logic [ADDR_WIDTH-1:0]     write_addr,
    input  logic [DATA_WIDTH/8-1:0]   write_be,
    input  logic [DATA_WIDTH-1:0]     write_data,
    input  logic                      read_en,
    input  logic [ADDR_WIDTH-1:0]     read_addr,
    output logic                      read_valid,
    output logic [DATA_WIDTH-1:0]     read_data
);
    localparam int DEPTH    = 1 << ADDR_WIDTH;
    localparam int BE_WIDTH = DATA_WIDTH / 8;

    typedef enum logic {CLEAR, READY} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   sweep_cnt_q, sweep_cnt_d;
    logic                    init_busy_q, init_busy_d;
    logic                    p_vld_q, p_vld_d;
    logic [DATA_WIDTH-1:0]   p_dat_q, p_dat_d;
    logic                    read_valid_q, read_valid_d;
    logic [DATA_WIDTH-1:0]   read_data_q, read_data_d;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_waddr;
    logic [BE_WIDTH-1:0]     mem_wbe;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic                    wr_acc;
    logic                    rd_acc;
    logic                    byp_hit;
    logic [DATA_WIDTH-1:0]   rd_word;

    always_comb begin
        state_d      = state_q;
        sweep_cnt_d  = sweep_cnt_q;
        init_busy_d  = init_busy_q;
        wr_acc       = (state_q == READY) && write_en;
        rd_acc       = (state_q == READY) && read_en;
        mem_we       = 1'b0;
        mem_waddr    = write_addr;
        mem_wbe      = write_be;
        mem_wdata    = write_data;

        case (state_q)
            CLEAR: begin
                mem_we      = 1'b1;
                mem_waddr   = sweep_cnt_q;
                mem_wbe     = '1;
                mem_wdata   = INIT_VALUE;
                sweep_cnt_d = sweep_cnt_q + 1'b1;
                // Leave CLEAR on the same edge that writes the last location.
                if (&sweep_cnt_q) begin
                    state_d     = READY;
                    init_busy_d = 1'b0;
                end
            end
            default: begin
                mem_we = wr_acc;
            end
        endcase

        // Reset blocks every memory write, sweep included.
        if (rst) begin
            mem_we = 1'b0;
        end
    end

    // Same-address collision: the read sees the old word unless forwarding is built in.
`ifdef RAM_2PORT_PIPE_BYPASS_EN
    assign byp_hit = wr_acc && (write_addr == read_addr);
`else
    assign byp_hit = 1'b0;
`endif

    always_comb begin
        rd_word = mem[read_addr];
        for (int b = 0; b < BE_WIDTH; b++) begin
            if (byp_hit && write_be[b]) begin
                rd_word[8*b +: 8] = write_data[8*b +: 8];
            end
        end
    end

    // Read pipeline: stage p only matters when READ_LATENCY is 2; the output
    // register only loads on a valid so read_data holds between pulses.
    always_comb begin
        p_vld_d = rd_acc;
        p_dat_d = rd_acc ? rd_word : p_dat_q;
        if (READ_LATENCY == 1) begin
            read_valid_d = rd_acc;
            read_data_d  = rd_acc ? rd_word : read_data_q;
        end else begin
            read_valid_d = p_vld_q;
            read_data_d  = p_vld_q ? p_dat_q : read_data_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= CLEAR;
            sweep_cnt_q  <= '0;
            init_busy_q  <= 1'b1;
            p_vld_q      <= 1'b0;
            p_dat_q      <= '0;
            read_valid_q <= 1'b0;
            read_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            sweep_cnt_q  <= sweep_cnt_d;
            init_busy_q  <= init_busy_d;
            p_vld_q      <= p_vld_d;
            p_dat_q      <= p_dat_d;
            read_valid_q <= read_valid_d;
            read_data_q  <= read_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < BE_WIDTH; b++) begin
                if (mem_wbe[b]) begin
                    mem[mem_waddr][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end
        end
    end

    assign init_busy  = init_busy_q;
    assign read_valid = read_valid_q;
    assign read_data  = read_data_q;

endmodule

// File: doc/ram_2port_pipe.md
RAM_2PORT_PIPE -- requirements
Module: ram_2port_pipe

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 6, address width; depth DEPTH = 2^ADDR_WIDTH.
REQ-002 SHALL have parameter DATA_WIDTH, default 64, word width; SHALL be a multiple of 8; BE_WIDTH = DATA_WIDTH/8.
REQ-003 SHALL have parameter READ_LATENCY, default 1, read latency in cycles; legal values 1 or 2.
REQ-004 SHALL have parameter INIT_VALUE, default 0, DATA_WIDTH-bit word written to every location by the init sweep.
REQ-005 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have port init_busy, output, 1, high while the init sweep runs.
REQ-008 SHALL have port write_en, input, 1, write request.
REQ-009 SHALL have port write_addr, input, ADDR_WIDTH, write address.
REQ-010 SHALL have port write_be, input, BE_WIDTH, byte enables; bit i selects write_data[8i+7:8i].
REQ-011 SHALL have port write_data, input, DATA_WIDTH, write data.
REQ-012 SHALL have port read_en, input, 1, read request.
REQ-013 SHALL have port read_addr, input, ADDR_WIDTH, read address.
REQ-014 SHALL have port read_valid, output, 1, one-cycle pulse marking read_data valid.
REQ-015 SHALL have port read_data, output, DATA_WIDTH, read result.

Function
REQ-016 SHALL implement a two-state FSM: CLEAR (init_busy=1) and READY (init_busy=0).
REQ-017 In CLEAR with rst low, SHALL write INIT_VALUE to location sweep_cnt each cycle and increment sweep_cnt from 0.
REQ-018 SHALL move CLEAR->READY on the edge that writes location DEPTH-1; init_busy SHALL be high for exactly DEPTH cycles after rst falls.
REQ-019 In CLEAR, write_en and read_en SHALL be ignored: no user write, no read_valid pulse.
REQ-020 In READY with write_en=1, SHALL update only the bytes whose write_be bit is 1; write_be=0 SHALL leave the word unchanged.
REQ-021 In READY, read_en=1 at edge N SHALL give read_valid=1 and read_data valid after edge N+READ_LATENCY-1 (sampled at edge N+READ_LATENCY), for exactly one cycle per request.
REQ-022 Reads SHALL be fully pipelined: back-to-back read_en every cycle SHALL give read_valid every cycle, in request order.
REQ-023 The returned word SHALL be the memory content as of edge N, after any collision handling in REQ-030/031; writes at later edges SHALL not affect an in-flight read.
REQ-024 read_data SHALL hold its last value while read_valid=0.
REQ-025 Simultaneous read and write to different addresses SHALL complete independently in the same cycle.

Reset
REQ-026 While rst=1 at an edge, SHALL set state CLEAR, sweep_cnt 0, read pipeline valid bits 0, read_data 0, read_valid 0, init_busy 1.
REQ-027 While rst=1, SHALL perform no memory writes.
REQ-028 Reset asserted mid-sweep or mid-read SHALL restart the sweep at location 0 and drop all in-flight reads, with no read_valid pulse.
REQ-029 Memory contents SHALL not be relied on before the sweep completes.

Configuration
REQ-030 With macro RAM_2PORT_PIPE_BYPASS_EN defined, a same-cycle read and write to the same address SHALL return the byte-merged word: enabled bytes from write_data, other bytes from the old memory word.
REQ-031 With RAM_2PORT_PIPE_BYPASS_EN undefined, a same-cycle same-address read SHALL return the old memory word (read-before-write); the write still completes.

Verification
REQ-032 Reset, DEPTH=64: rst high 3 cycles, then low -> init_busy high exactly 64 cycles; then every address reads INIT_VALUE.
REQ-033 READY, READ_LATENCY=1: write 0x1122334455667788 to addr 5 with be=0xFF; read addr 5 next cycle -> read_valid one edge later with that data.
REQ-034 Byte enable: addr 5 holds 0x1122334455667788; write 0xAAAAAAAAAAAAAAAA with be=0x0F -> read returns 0x11223344AAAAAAAA.
REQ-035 Collision: addr 7 holds 0; same-cycle write 0xFFFF...FF be=0x01 and read addr 7 -> 0x00000000000000FF with bypass, 0 without.
REQ-036 READ_LATENCY=2: read_en every cycle on addrs 0,1,2,3 -> read_valid high 4 consecutive cycles starting 2 edges after the first request, data in order.
REQ-037 Mid-sweep reset: assert rst when sweep_cnt=30 -> sweep restarts at 0; init_busy high 64 more cycles; a read_en issued before the reset produces no read_valid.
